ram_burst_reader: RTL and testbench

//  Read-side engine for simple_dual_port_ram_asym: accepts (start address, length) burst commands,

---
 rtl/ram_burst_reader.sv | 180 ++++++++++++++++++
 tb/tb_ram_burst_reader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
// ram_burst_reader
//   Read-side burst engine for simple_dual_port_ram_asym. Accepts (address, length)
//   commands, issues one RAM read per cycle while credits allow, tracks the RAM's
//   fixed read latency and streams the words out on a valid/ready port with a
//   last marker. A 4-entry holding buffer absorbs reads already in flight when
//   the consumer stalls. A read is only issued while reads in the RAM pipeline
//   plus words in the buffer number fewer than 4, so every returning word has a slot.
//
// Ports
//   rclk       single clock, shared with the RAM read port
//   rst        synchronous active-high reset
//   cmd_valid  command valid
//   cmd_ready  command accepted on cmd_valid & cmd_ready
//   cmd_addr   first word address
//   cmd_len    burst length in words (0 = no reads, done pulse only)
//   raddr/re   RAM read port
//   rdata      RAM read data, valid RD_LAT cycles after re
//   m_valid    output word valid
//   m_ready    consumer ready
//   m_data     output word
//   m_last     final word of the burst, qualified by m_valid
//   busy       command in progress, through the done cycle
//   done       one-cycle pulse when the burst is complete
//
// FSM
//   state   | meaning
//   S_IDLE  | waiting for a command; cmd_ready high unless a done pulse is showing
//   S_ISSUE | issuing reads while words remain and credits are available
//   S_DRAIN | all reads issued; waiting for the last beat to be handshaken

module ram_burst_reader #(
    parameter int    RD_ADDR_WIDTH = 9,
    parameter int    RD_DATA_WIDTH = 8,
    parameter int    LEN_WIDTH     = 10,
    parameter string OUTPUT_REG    = "TRUE"
) (
    input  logic                     rclk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [RD_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    output logic [RD_ADDR_WIDTH-1:0] raddr,
    output logic                     re,
    input  logic [RD_DATA_WIDTH-1:0] rdata,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [RD_DATA_WIDTH-1:0] m_data,
    output logic                     m_last,
    output logic                     busy,
    output logic                     done
);

    localparam int RD_LAT    = (OUTPUT_REG == "TRUE") ? 2 : 1;
    localparam int BUF_DEPTH = 4;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

    state_t                   state_q, state_d;
    logic [RD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]     remaining_q, remaining_d;
    logic                     done_q, done_d;

    // pipe_v_q[RD_LAT-1] high means rdata carries a requested word this cycle
    logic [RD_LAT-1:0]        pipe_v_q;
    logic [RD_LAT-1:0]        pipe_last_q;

    logic [RD_DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];
    logic                     buf_last_q [BUF_DEPTH];
    logic [1:0]               wr_ptr_q, rd_ptr_q;
    logic [2:0]               count_q;

    logic [2:0]               inflight;
    logic [2:0]               outstanding;
    logic                     accept, issue, last_issue, capture, pop;

    always_comb begin
        inflight = 3'd0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + {2'b00, pipe_v_q[i]};
        end
    end

    assign outstanding = inflight + count_q;
    assign cmd_ready   = (state_q == S_IDLE) && !done_q && !rst;
    assign accept      = cmd_valid && cmd_ready;
    assign issue       = (state_q == S_ISSUE) && (remaining_q != '0)
                         && (outstanding < 3'(BUF_DEPTH));
    assign last_issue  = issue && (remaining_q == LEN_WIDTH'(1));
    assign capture     = pipe_v_q[RD_LAT-1];
    assign m_valid     = (count_q != 3'd0);
    assign pop         = m_valid && m_ready;
    assign m_data      = buf_data_q[rd_ptr_q];
    assign m_last      = buf_last_q[rd_ptr_q] && m_valid;
    assign re          = issue;
    assign raddr       = addr_q;
    assign done        = done_q;
    assign busy        = (state_q != S_IDLE) || done_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d      = cmd_addr;
                        remaining_d = cmd_len;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + RD_ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (last_issue) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop && m_last && (inflight == 3'd0)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            done_q      <= 1'b0;
            pipe_v_q    <= '0;
            pipe_last_q <= '0;
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            count_q     <= 3'd0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buf_data_q[i] <= '0;
                buf_last_q[i] <= 1'b0;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            done_q      <= done_d;

            pipe_v_q[0]    <= issue;
            pipe_last_q[0] <= last_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_v_q[i]    <= pipe_v_q[i-1];
                pipe_last_q[i] <= pipe_last_q[i-1];
            end

            if (capture) begin
                buf_data_q[wr_ptr_q] <= rdata;
                buf_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
                wr_ptr_q             <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            unique case ({capture, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_burst_reader.sv
module tb_ram_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] cmd_addr;
    logic [9:0] cmd_len;
    logic       m_ready;

    logic       cmd_valid_a, cmd_ready_a, re_a, m_valid_a, m_last_a, busy_a, done_a;
    logic [8:0] raddr_a;
    logic [7:0] rdata_a, m_data_a, ra_s1;

    logic       cmd_valid_b, cmd_ready_b, re_b, m_valid_b, m_last_b, busy_b, done_b;
    logic [8:0] raddr_b;
    logic [7:0] rdata_b, m_data_b;

    logic [7:0] ram [512];

    typedef struct packed {logic [7:0] data; logic last;} exp_t;
    exp_t exp_q[$];
    exp_t exp_b[$];
    logic [8:0] raddr_log[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cyc, a_lat;
    int beats, first_cyc, last_cyc, done_cyc, done_cnt;
    int re_cnt, re_first, re_last, issued, popped, max_out;
    logic       stall_prev;
    logic [7:0] stall_data;
    logic       stall_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ram_burst_reader #(.RD_ADDR_WIDTH(9), .RD_DATA_WIDTH(8), .LEN_WIDTH(10), .OUTPUT_REG("TRUE")) dut_a (
        .rclk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .raddr(raddr_a), .re(re_a), .rdata(rdata_a),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_data(m_data_a), .m_last(m_last_a),
        .busy(busy_a), .done(done_a));

    ram_burst_reader #(.RD_ADDR_WIDTH(9), .RD_DATA_WIDTH(8), .LEN_WIDTH(10), .OUTPUT_REG("FALSE")) dut_b (
        .rclk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .raddr(raddr_b), .re(re_b), .rdata(rdata_b),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_data(m_data_b), .m_last(m_last_b),
        .busy(busy_b), .done(done_b));

    // RAM read-port models: two-cycle (output register) and one-cycle latency
    always @(posedge clk) begin
        if (re_a) ra_s1 <= ram[raddr_a];
        rdata_a <= ra_s1;
        if (re_b) rdata_b <= ram[raddr_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_stats();
        beats = 0; first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
        re_cnt = 0; re_first = -1; re_last = -1; issued = 0; popped = 0; max_out = 0;
        raddr_log.delete();
    endtask

    function automatic void push_burst(input logic [8:0] addr, input int len, input bit to_b);
        exp_t e;
        logic [8:0] ai;
        for (int i = 0; i < len; i++) begin
            ai = addr + 9'(i);
            e.data = ram[ai];
            e.last = (i == len - 1);
            if (to_b) exp_b.push_back(e);
            else exp_q.push_back(e);
        end
    endfunction

    // Monitor for instance A: scoreboard pop, stall stability, credit and timing stats
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (re_a) begin
                issued++; re_cnt++;
                if (re_cnt == 1) re_first = cyc;
                re_last = cyc;
                raddr_log.push_back(raddr_a);
            end
            if (stall_prev) begin
                chk("stall_valid", m_valid_a, 1'b1);
                chk("stall_data", m_data_a, stall_data);
                chk("stall_last", m_last_a, stall_last);
            end
            if (m_valid_a && m_ready) begin
                popped++; beats++;
                if (beats == 1) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_beat: observed data=0x%0h expected no beat", m_data_a);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", m_data_a, e.data);
                    chk("beat_last", m_last_a, e.last);
                end
                if (m_last_a) last_cyc = cyc;
            end
            stall_prev = m_valid_a && !m_ready;
            stall_data = m_data_a;
            stall_last = m_last_a;
            if (done_a) begin done_cnt++; done_cyc = cyc; end
            if (issued - popped > max_out) max_out = issued - popped;
        end
    end

    task automatic send_a(input logic [8:0] addr, input logic [9:0] len);
        int n;
        @(posedge clk); #1;
        cmd_addr = addr; cmd_len = len; cmd_valid_a = 1'b1;
        n = 0;
        @(negedge clk);
        while (cmd_ready_a !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("cmd_accept", cmd_ready_a, 1'b1);
        acc_cyc = cyc;
        push_burst(addr, int'(len), 1'b0);
        @(posedge clk); #1;
        cmd_valid_a = 1'b0;
    endtask

    task automatic wait_burst(input int bound, input string tag);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin @(negedge clk); n++; end
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_done_once"}, done_cnt, 1);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int n, fb, lb, db, bcnt;
        exp_t e;
        for (int i = 0; i < 512; i++) ram[i] = 8'(i);
        rst = 1'b1; cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
        cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready_a, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_re", re_a, 1'b0);
        chk("rst_raddr", raddr_a, 9'h000);
        chk("rst_m_valid", m_valid_a, 1'b0);
        chk("rst_m_data", m_data_a, 8'h00);
        chk("rst_m_last", m_last_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("idle_cmd_ready", cmd_ready_a, 1'b1);

        // 1: basic burst, RD_LAT=2
        clear_stats();
        send_a(9'h010, 10'd4);
        wait_burst(40, "t1");
        a_lat = first_cyc - acc_cyc;
        chk("t1_first_beat_latency", a_lat, 4);
        chk("t1_re_count", re_cnt, 4);
        chk("t1_re_consecutive", re_last - re_first, 3);
        chk("t1_issue_after_accept", re_first - acc_cyc, 1);
        chk("t1_beats", beats, 4);
        chk("t1_back_to_back", last_cyc - first_cyc, 3);
        chk("t1_done_after_last", done_cyc - last_cyc, 1);
        chk("t1_idle_busy", busy_a, 1'b0);

        // 2: address wrap
        clear_stats();
        send_a(9'h1FE, 10'd4);
        wait_burst(40, "t2");
        chk("t2_raddr_count", raddr_log.size(), 4);
        if (raddr_log.size() == 4) begin
            chk("t2_raddr0", raddr_log[0], 9'h1FE);
            chk("t2_raddr1", raddr_log[1], 9'h1FF);
            chk("t2_raddr2", raddr_log[2], 9'h000);
            chk("t2_raddr3", raddr_log[3], 9'h001);
        end
        chk("t2_beats", beats, 4);

        // 3: backpressure with toggling ready and a 10-cycle hold low
        clear_stats();
        send_a(9'h040, 10'd16);
        for (int i = 0; i < 36; i++) begin
            if (i < 12)      m_ready = i[0];
            else if (i < 22) m_ready = 1'b0;
            else if (i < 30) m_ready = ~i[0];
            else             m_ready = 1'b1;
            @(posedge clk); #1;
        end
        m_ready = 1'b1;
        wait_burst(100, "t3");
        chk("t3_max_outstanding", max_out, 4);
        chk("t3_beats", beats, 16);
        chk("t3_re_count", re_cnt, 16);

        // 4: zero-length command
        clear_stats();
        send_a(9'h055, 10'd0);
        @(negedge clk);
        chk("t4_done_pulse", done_a, 1'b1);
        chk("t4_cmd_ready_low", cmd_ready_a, 1'b0);
        @(negedge clk);
        chk("t4_cmd_ready_back", cmd_ready_a, 1'b1);
        chk("t4_done_cleared", done_a, 1'b0);
        chk("t4_no_re", re_cnt, 0);
        chk("t4_no_beats", beats, 0);

        // 5: reset in the middle of a burst
        clear_stats();
        send_a(9'h080, 10'd8);
        n = 0;
        while (beats < 3 && n < 40) begin @(negedge clk); n++; end
        chk("t5_reached_3_beats", beats >= 3, 1'b1);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_cmd_ready", cmd_ready_a, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_re", re_a, 1'b0);
        chk("t5_raddr", raddr_a, 9'h000);
        chk("t5_m_valid", m_valid_a, 1'b0);
        chk("t5_m_data", m_data_a, 8'h00);
        chk("t5_m_last", m_last_a, 1'b0);
        chk("t5_busy", busy_a, 1'b0);
        chk("t5_done", done_a, 1'b0);
        exp_q.delete();
        clear_stats();
        send_a(9'h000, 10'd2);
        wait_burst(40, "t5b");
        chk("t5b_beats", beats, 2);

        // 6: single-cycle RAM latency instance
        @(posedge clk); #1;
        cmd_addr = 9'h010; cmd_len = 10'd4; cmd_valid_b = 1'b1;
        n = 0;
        @(negedge clk);
        while (cmd_ready_b !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        chk("t6_cmd_accept", cmd_ready_b, 1'b1);
        acc_cyc = cyc;
        push_burst(9'h010, 4, 1'b1);
        @(posedge clk); #1 cmd_valid_b = 1'b0;
        fb = -1; lb = -1; db = -1; bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m_valid_b) begin
                bcnt++;
                if (fb < 0) fb = cyc;
                if (m_last_b) lb = cyc;
                if (exp_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL t6_unexpected_beat: observed data=0x%0h expected no beat", m_data_b);
                end else begin
                    e = exp_b.pop_front();
                    chk("t6_beat_data", m_data_b, e.data);
                    chk("t6_beat_last", m_last_b, e.last);
                end
            end
            if (done_b) db = cyc;
        end
        chk("t6_first_beat_latency", fb - acc_cyc, 3);
        chk("t6_one_cycle_earlier", fb - acc_cyc, a_lat - 1);
        chk("t6_beats", bcnt, 4);
        chk("t6_back_to_back", lb - fb, 3);
        chk("t6_done_after_last", db - lb, 1);
        chk("t6_sb_empty", exp_b.size(), 0);
        chk("t6_idle_busy", busy_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
